// File: rtl/mux_nbits_pkg.sv
// Shared constants, lock-state encoding and round-robin pick function for mux_nbits_rr.
package mux_nbits_pkg;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE,
      LOCKED
   } lock_state_e;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_pick_t;

   // First requesting channel scanning ptr, ptr+1, ... with natural 2-bit wrap.
   function automatic rr_pick_t rr_pick(input logic [N_CH-1:0] req, input logic [SEL_W-1:0] ptr);
      rr_pick_t         r;
      logic [SEL_W-1:0] c;
      r = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         c = ptr + SEL_W'(i);
         if (!r.found && req[c]) begin
            r.found = 1'b1;
            r.idx   = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_nbits_rr_if.sv
// Four-channel valid/ready input bundle plus the merged output stream.
interface mux_nbits_rr_if #(
   parameter int unsigned bits = 2
);
   logic [bits-1:0] in_0;
   logic [bits-1:0] in_1;
   logic [bits-1:0] in_2;
   logic [bits-1:0] in_3;
   logic [3:0]      in_valid;
   logic [3:0]      in_last;
   logic [3:0]      in_ready;
   logic [bits-1:0] out;
   logic [1:0]      out_sel;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output in_0, in_1, in_2, in_3, in_valid, in_last, out_ready,
      input  in_ready, out, out_sel, out_last, out_valid
   );

   modport slave (
      input  in_0, in_1, in_2, in_3, in_valid, in_last, out_ready,
      output in_ready, out, out_sel, out_last, out_valid
   );
endinterface

// File: rtl/mux_nbits_rr_arbiter4.sv
// Combinational four-way round-robin arbiter; pointer is owned by the caller.
module rr_arbiter4
   import mux_nbits_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             enable,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] idx,
   output logic             any
);
   rr_pick_t pick;

   always_comb begin
      pick = rr_pick(req, ptr);
      any  = enable && pick.found;
      idx  = pick.idx;
      gnt  = any ? (N_CH'(1) << pick.idx) : '0;
   end
endmodule

// File: rtl/mux_nbits_rr.sv
// Four-to-one round-robin stream merger with one output register.
// Optional whole-line grant hold via MUX_NBITS_RR_PKT_LOCK_EN.
module mux_nbits_rr
   import mux_nbits_pkg::*;
#(
   parameter int unsigned     bits      = 2,
   parameter logic [bits-1:0] otherwise = '0
) (
   input logic            clk,
   input logic            rst,
   mux_nbits_rr_if.slave  bus
);
   logic [bits-1:0]  data [N_CH];
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  gnt;
   logic [SEL_W-1:0] idx;
   logic             any;
   logic             load;

   logic [SEL_W-1:0] ptr_q;
   logic [bits-1:0]  out_q;
   logic [SEL_W-1:0] sel_q;
   logic             last_q;
   logic             valid_q;

   assign data[0] = bus.in_0;
   assign data[1] = bus.in_1;
   assign data[2] = bus.in_2;
   assign data[3] = bus.in_3;

   assign load = !valid_q || bus.out_ready;

`ifdef MUX_NBITS_RR_PKT_LOCK_EN
   lock_state_e      state_q, state_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         lock_ch_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
      end
   end

   // Request masking is kept apart from next-state logic to avoid a false comb loop through the arbiter.
   always_comb begin
      req = bus.in_valid;
      if (state_q == LOCKED) req = bus.in_valid & (N_CH'(1) << lock_ch_q);
   end

   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      if (any) begin
         if (bus.in_last[idx]) begin
            state_d = IDLE;
         end else begin
            state_d   = LOCKED;
            lock_ch_d = idx;
         end
      end
   end
`else
   assign req = bus.in_valid;
`endif

   rr_arbiter4 u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .enable (load),
      .gnt    (gnt),
      .idx    (idx),
      .any    (any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         out_q   <= otherwise;
         sel_q   <= '0;
         last_q  <= 1'b0;
         ptr_q   <= '0;
      end else if (load) begin
         if (any) begin
            out_q   <= data[idx];
            sel_q   <= idx;
            last_q  <= bus.in_last[idx];
            valid_q <= 1'b1;
            ptr_q   <= idx + SEL_W'(1);
         end else begin
            valid_q <= 1'b0;
            out_q   <= otherwise;
         end
      end
   end

   assign bus.in_ready  = gnt;
   assign bus.out       = out_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_last  = last_q;
   assign bus.out_valid = valid_q;
endmodule
